// File: rtl/lane_sprite_mover.sv
// Lane-based player sprite engine: erases and redraws a rectangular sprite on lane moves,
// streaming pixels over a valid/ready write port with one buffered move and one buffered redraw.
module lane_sprite_mover #(
  parameter int nX            = 10,
  parameter int nY            = 9,
  parameter int COLOR_DEPTH   = 9,
  parameter int NUM_LANES     = 5,
  parameter int LANE_BITS     = 3,
  parameter int START_LANE    = 2,
  parameter int LANE_WIDTH    = 80,
  parameter int LANE_START_X  = 120,
  parameter int PLAYER_WIDTH  = 60,
  parameter int PLAYER_HEIGHT = 60,
  parameter int PLAYER_Y_POS  = 360,
  parameter logic [COLOR_DEPTH-1:0] PLAYER_COLOR = 9'b000_111_111,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR     = 9'b000_000_000
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   move_left,
  input  logic                   move_right,
  input  logic                   redraw,
  input  logic                   VGA_ready,
  output logic [LANE_BITS-1:0]   player_lane,
  output logic [nX-1:0]          VGA_x,
  output logic [nY-1:0]          VGA_y,
  output logic [COLOR_DEPTH-1:0] VGA_color,
  output logic                   VGA_write,
  output logic                   busy
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ERASE, S_DRAW} state_t;
  typedef enum logic [1:0] {MV_NONE, MV_LEFT, MV_RIGHT} move_t;

  localparam logic [LANE_BITS-1:0] START_L   = LANE_BITS'(START_LANE);
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(NUM_LANES - 1);
  localparam logic [nX-1:0]        X_OFF     = nX'(LANE_START_X + (LANE_WIDTH - PLAYER_WIDTH) / 2);
  localparam logic [nX-1:0]        X_PITCH   = nX'(LANE_WIDTH);
  localparam logic [nX-1:0]        PX_LAST   = nX'(PLAYER_WIDTH - 1);
  localparam logic [nY-1:0]        PY_LAST   = nY'(PLAYER_HEIGHT - 1);
  localparam logic [nY-1:0]        Y_TOP     = nY'(PLAYER_Y_POS);

  // Modular nX-bit arithmetic gives the same truncated result as a wide computation.
  function automatic logic [nX-1:0] lane_to_x(input logic [LANE_BITS-1:0] lane);
    return X_OFF + nX'(lane) * X_PITCH;
  endfunction

  state_t                 state_reg, state_next;
  move_t                  pend_move_reg, pend_move_next;
  logic                   pend_redraw_reg, pend_redraw_next;
  logic [LANE_BITS-1:0]   lane_reg, lane_next;
  logic [nX-1:0]          old_x_reg, old_x_next;
  logic [nX-1:0]          px_reg, px_next;
  logic [nY-1:0]          py_reg, py_next;
  logic                   left_q, right_q, redraw_q;
  logic                   left_rise, right_rise, redraw_rise;
  logic                   consume, redraw_clr;
  logic [nX-1:0]          base_x;

  assign left_rise   = move_left  & ~left_q;
  assign right_rise  = move_right & ~right_q;
  assign redraw_rise = redraw     & ~redraw_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg       <= S_INIT;
      pend_move_reg   <= MV_NONE;
      pend_redraw_reg <= 1'b0;
      lane_reg        <= START_L;
      old_x_reg       <= '0;
      px_reg          <= '0;
      py_reg          <= '0;
      left_q          <= 1'b0;
      right_q         <= 1'b0;
      redraw_q        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pend_move_reg   <= pend_move_next;
      pend_redraw_reg <= pend_redraw_next;
      lane_reg        <= lane_next;
      old_x_reg       <= old_x_next;
      px_reg          <= px_next;
      py_reg          <= py_next;
      left_q          <= move_left;
      right_q         <= move_right;
      redraw_q        <= redraw;
    end
  end

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    old_x_next = old_x_reg;
    px_next    = px_reg;
    py_next    = py_reg;
    consume    = 1'b0;
    redraw_clr = 1'b0;
    case (state_reg)
      S_INIT: begin
        state_next = S_DRAW;
        lane_next  = START_L;
        px_next    = '0;
        py_next    = '0;
      end
      S_IDLE: begin
        px_next = '0;
        py_next = '0;
        if (pend_move_reg != MV_NONE) begin
          consume = 1'b1;
          // Moves that would leave the lane range are dropped silently.
          if (pend_move_reg == MV_LEFT && lane_reg != '0) begin
            old_x_next = lane_to_x(lane_reg);
            lane_next  = lane_reg - LANE_BITS'(1);
            state_next = S_ERASE;
            redraw_clr = 1'b1;
          end else if (pend_move_reg == MV_RIGHT && lane_reg != LAST_LANE) begin
            old_x_next = lane_to_x(lane_reg);
            lane_next  = lane_reg + LANE_BITS'(1);
            state_next = S_ERASE;
            redraw_clr = 1'b1;
          end
        end else if (pend_redraw_reg) begin
          state_next = S_DRAW;
          redraw_clr = 1'b1;
        end
      end
      S_ERASE, S_DRAW: begin
        if (VGA_ready) begin
          if (px_reg == PX_LAST) begin
            px_next = '0;
            if (py_reg == PY_LAST) begin
              py_next    = '0;
              state_next = (state_reg == S_ERASE) ? S_DRAW : S_IDLE;
            end else begin
              py_next = py_reg + nY'(1);
            end
          end else begin
            px_next = px_reg + nX'(1);
          end
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  // A fresh rise always wins over consumption so edges landing on the consume cycle survive.
  always_comb begin
    pend_move_next = pend_move_reg;
    if (left_rise && !right_rise)
      pend_move_next = MV_LEFT;
    else if (right_rise && !left_rise)
      pend_move_next = MV_RIGHT;
    else if (consume)
      pend_move_next = MV_NONE;

    pend_redraw_next = pend_redraw_reg;
    if (redraw_rise)
      pend_redraw_next = 1'b1;
    else if (redraw_clr)
      pend_redraw_next = 1'b0;
  end

  assign base_x      = (state_reg == S_ERASE) ? old_x_reg : lane_to_x(lane_reg);
  assign VGA_write   = (state_reg == S_ERASE) || (state_reg == S_DRAW);
  assign VGA_x       = VGA_write ? base_x + px_reg : '0;
  assign VGA_y       = VGA_write ? Y_TOP + py_reg : '0;
  assign VGA_color   = !VGA_write ? '0 : ((state_reg == S_ERASE) ? BG_COLOR : PLAYER_COLOR);
  assign player_lane = lane_reg;
  assign busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_lane_sprite_mover.sv
// Randomised bench for lane_sprite_mover: a queue-based model of expected pixel writes,
// lane and busy is compared against the DUT every cycle.
module tb_lane_sprite_mover;
  localparam int W = 60, H = 60, NL = 5, START = 2;
  localparam int PCOL = 'h03F, BGCOL = 0;

  logic       Clock = 1'b0, Resetn = 1'b0;
  logic       move_left = 1'b0, move_right = 1'b0, redraw = 1'b0, VGA_ready = 1'b0;
  logic [2:0] player_lane;
  logic [9:0] VGA_x;
  logic [8:0] VGA_y;
  logic [8:0] VGA_color;
  logic       VGA_write, busy;

  lane_sprite_mover dut (
    .Clock(Clock), .Resetn(Resetn), .move_left(move_left), .move_right(move_right),
    .redraw(redraw), .VGA_ready(VGA_ready), .player_lane(player_lane), .VGA_x(VGA_x),
    .VGA_y(VGA_y), .VGA_color(VGA_color), .VGA_write(VGA_write), .busy(busy)
  );

  always #5 Clock = ~Clock;

  typedef struct packed { logic [9:0] x; logic [8:0] y; logic [8:0] c; } pix_t;
  pix_t exp_q[$];
  int   m_lane, m_pend;  // m_pend: 0 none, 1 left, 2 right
  bit   m_init, m_redraw, pl, pr, prd, lr, rr, dr, consumed, started;
  bit   rnd_ready = 1'b0;
  int   n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lane_x(input int l);
    return 120 + l * 80 + (80 - W) / 2;
  endfunction

  function automatic void push_rect(input int bx, input int col);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        pix_t p;
        p.x = 10'(bx + xx);
        p.y = 9'(360 + yy);
        p.c = 9'(col);
        exp_q.push_back(p);
      end
  endfunction

  // Reference model: an operation is a rectangle of expected pixels; the sprite is idle when none remain.
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      exp_q.delete();
      m_lane = START; m_init = 1'b1; m_pend = 0; m_redraw = 1'b0;
      pl = 1'b0; pr = 1'b0; prd = 1'b0;
    end else begin
      lr = move_left && !pl;
      rr = move_right && !pr;
      dr = redraw && !prd;
      consumed = 1'b0;
      started  = 1'b0;
      if (m_init) begin
        m_init = 1'b0;
        push_rect(lane_x(m_lane), PCOL);
      end else if (exp_q.size() == 0) begin
        if (m_pend != 0) begin
          consumed = 1'b1;
          if ((m_pend == 1 && m_lane > 0) || (m_pend == 2 && m_lane < NL - 1)) begin
            push_rect(lane_x(m_lane), BGCOL);
            m_lane = (m_pend == 1) ? m_lane - 1 : m_lane + 1;
            push_rect(lane_x(m_lane), PCOL);
            started = 1'b1;
          end
        end else if (m_redraw) begin
          push_rect(lane_x(m_lane), PCOL);
          started = 1'b1;
        end
      end else if (VGA_ready) begin
        void'(exp_q.pop_front());
      end
      if (lr && !rr)      m_pend = 1;
      else if (rr && !lr) m_pend = 2;
      else if (consumed)  m_pend = 0;
      if (dr)             m_redraw = 1'b1;
      else if (started)   m_redraw = 1'b0;
      pl = move_left; pr = move_right; prd = redraw;
    end
  end

  always @(negedge Clock) begin
    if (exp_q.size() != 0) begin
      check_eq("vga_write", VGA_write, 1);
      check_eq("vga_x", VGA_x, exp_q[0].x);
      check_eq("vga_y", VGA_y, exp_q[0].y);
      check_eq("vga_color", VGA_color, exp_q[0].c);
    end else begin
      check_eq("vga_write_idle", VGA_write, 0);
      check_eq("vga_x_idle", VGA_x, 0);
      check_eq("vga_y_idle", VGA_y, 0);
      check_eq("vga_color_idle", VGA_color, 0);
    end
    check_eq("busy", busy, (m_init || exp_q.size() != 0) ? 1 : 0);
    check_eq("player_lane", player_lane, m_lane);
  end

  always @(negedge Clock)
    VGA_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;

  task automatic pulse(input bit l, input bit r, input bit d);
    move_left = l; move_right = r; redraw = d;
    @(negedge Clock);
    move_left = 1'b0; move_right = 1'b0; redraw = 1'b0;
    @(negedge Clock);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((m_init || exp_q.size() != 0 || m_pend != 0 || m_redraw) && n < limit) begin
      @(negedge Clock);
      n++;
    end
    check_eq("idle_reached", (n < limit) ? 1 : 0, 1);
    repeat ($urandom_range(1, 4)) @(negedge Clock);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    wait_idle(5000);
    check_eq("lane_after_init", player_lane, START);

    pulse(0, 1, 0); wait_idle(10000);
    pulse(0, 1, 0); wait_idle(10000);
    pulse(0, 1, 0); repeat (6) @(negedge Clock);
    check_eq("lane_top_clamp", player_lane, 4);

    // Queue right, right, left during a DRAW: only the left survives.
    pulse(1, 0, 0);
    n = 0;
    while (exp_q.size() > 3000 && n < 10000) begin @(negedge Clock); n++; end
    check_eq("reached_draw", (n < 10000) ? 1 : 0, 1);
    pulse(0, 1, 0); pulse(0, 1, 0); pulse(1, 0, 0);
    wait_idle(20000);
    check_eq("lane_after_queue", player_lane, 2);

    pulse(1, 0, 0); wait_idle(10000);
    pulse(1, 0, 0); wait_idle(10000);
    pulse(1, 0, 0); repeat (6) @(negedge Clock);
    check_eq("lane_bottom_clamp", player_lane, 0);
    pulse(1, 1, 0); repeat (6) @(negedge Clock);
    check_eq("lane_both_ignored", player_lane, 0);

    rnd_ready = 1'b1;
    pulse(0, 1, 0); wait_idle(40000);
    rnd_ready = 1'b0;

    pulse(0, 1, 0);
    repeat (500) @(negedge Clock);
    #2 Resetn = 1'b0;
    @(negedge Clock);
    check_eq("reset_write", VGA_write, 0);
    check_eq("reset_lane", player_lane, START);
    Resetn = 1'b1;
    wait_idle(5000);

    pulse(0, 0, 1); wait_idle(5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
